match_controller: RTL and testbench

//  Round/match sequencer for the two-player fighting game. Drives the game core's reset and

---
 rtl/match_controller_if.sv | 31 +++
 rtl/match_controller.sv | 177 +++++++++++++++++
 tb/tb_match_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/match_controller_if.sv
// Bundle of the controller's game-side signals: match start request and
// health inputs in, core gating and scoreboard status out.
interface match_controller_if;
  logic       start;
  logic [2:0] right_health;
  logic [2:0] left_health;
  logic       game_rst_n;
  logic       input_enable;
  logic [2:0] state;
  logic [7:0] round_time;
  logic [2:0] round_num;
  logic [1:0] right_wins;
  logic [1:0] left_wins;
  logic [1:0] round_winner;
  logic [1:0] match_winner;
  logic       match_done;

  // Controller side
  modport slave (
    input  start, right_health, left_health,
    output game_rst_n, input_enable, state, round_time, round_num,
           right_wins, left_wins, round_winner, match_winner, match_done
  );

  // Game top / driver side
  modport master (
    output start, right_health, left_health,
    input  game_rst_n, input_enable, state, round_time, round_num,
           right_wins, left_wins, round_winner, match_winner, match_done
  );
endinterface

// File: rtl/match_controller.sv
// Round/match sequencer: gates the game core, runs the round clock, judges
// KO/timeout, tallies round wins and declares the best-of-N match winner.
module match_controller #(
  parameter int TICK_DIV        = 1000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int ROUND_TICKS     = 60,
  parameter int WINS_TO_MATCH   = 2,
  parameter int MAX_ROUNDS      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  match_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_RESET_PLAYERS = 3'd1,
    ST_COUNTDOWN     = 3'd2,
    ST_FIGHT         = 3'd3,
    ST_ROUND_END     = 3'd4,
    ST_MATCH_OVER    = 3'd5
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = (COUNTDOWN_TICKS > 1) ? $clog2(COUNTDOWN_TICKS) : 1;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_LEFT  = 2'b01;
  localparam logic [1:0] RES_RIGHT = 2'b10;
  localparam logic [1:0] RES_DRAW  = 2'b11;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   cd_q, cd_d;
  logic [7:0]      rt_q, rt_d;
  logic [2:0]      rn_q, rn_d;
  logic [1:0]      lw_q, lw_d;
  logic [1:0]      rw_q, rw_d;
  logic [1:0]      rwin_q, rwin_d;
  logic [1:0]      mwin_q, mwin_d;
  logic            grst_n_q, ie_q, done_q;
  logic            tick;
  logic [1:0]      result;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // KO/timeout judge; KO always outranks the timeout comparison
  always_comb begin
    result = RES_NONE;
    if (bus.left_health == 3'd0 && bus.right_health == 3'd0) result = RES_DRAW;
    else if (bus.left_health == 3'd0)                        result = RES_RIGHT;
    else if (bus.right_health == 3'd0)                       result = RES_LEFT;
    else if (rt_q == 8'd0) begin
      if (bus.left_health > bus.right_health)      result = RES_LEFT;
      else if (bus.right_health > bus.left_health) result = RES_RIGHT;
      else                                         result = RES_DRAW;
    end
  end

  // Next-state, scoreboard and timer updates
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    rt_d    = rt_q;
    rn_d    = rn_q;
    lw_d    = lw_q;
    rw_d    = rw_q;
    rwin_d  = rwin_q;
    mwin_d  = mwin_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RESET_PLAYERS;
          lw_d    = 2'd0;
          rw_d    = 2'd0;
          rn_d    = 3'd0;
          rwin_d  = RES_NONE;
        end
      end
      ST_RESET_PLAYERS: begin
        // prescaler doubles as the two-cycle hold counter
        if (presc_q == PW'(1)) state_d = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (tick) begin
          if (cd_q == CW'(COUNTDOWN_TICKS - 1)) begin
            state_d = ST_FIGHT;
            rt_d    = 8'(ROUND_TICKS);
          end else begin
            cd_d = cd_q + 1'b1;
          end
        end
      end
      ST_FIGHT: begin
        if (tick && rt_q != 8'd0) rt_d = rt_q - 8'd1;
        if (result != RES_NONE) begin
          // wins and round count land on the ROUND_END entry edge
          state_d = ST_ROUND_END;
          rwin_d  = result;
          rn_d    = rn_q + 3'd1;
          if (result == RES_LEFT)  lw_d = lw_q + 2'd1;
          if (result == RES_RIGHT) rw_d = rw_q + 2'd1;
        end
      end
      ST_ROUND_END: begin
        if (tick) begin
          if (lw_q == 2'(WINS_TO_MATCH) || rw_q == 2'(WINS_TO_MATCH) ||
              rn_q == 3'(MAX_ROUNDS)) begin
            state_d = ST_MATCH_OVER;
            if (lw_q > rw_q)      mwin_d = RES_LEFT;
            else if (rw_q > lw_q) mwin_d = RES_RIGHT;
            else                  mwin_d = RES_DRAW;
          end else begin
            state_d = ST_RESET_PLAYERS;
          end
        end
      end
      ST_MATCH_OVER: begin
        if (bus.start) begin
          state_d = ST_RESET_PLAYERS;
          lw_d    = 2'd0;
          rw_d    = 2'd0;
          rn_d    = 3'd0;
          rwin_d  = RES_NONE;
          mwin_d  = RES_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // every state entry restarts tick timing and the countdown tally
    if (state_d != state_q) cd_d = '0;
    presc_d = (state_d != state_q || tick) ? '0 : presc_q + 1'b1;
  end

  // State, counters and registered core-control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      cd_q     <= '0;
      rt_q     <= 8'd0;
      rn_q     <= 3'd0;
      lw_q     <= 2'd0;
      rw_q     <= 2'd0;
      rwin_q   <= RES_NONE;
      mwin_q   <= RES_NONE;
      grst_n_q <= 1'b0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cd_q     <= cd_d;
      rt_q     <= rt_d;
      rn_q     <= rn_d;
      lw_q     <= lw_d;
      rw_q     <= rw_d;
      rwin_q   <= rwin_d;
      mwin_q   <= mwin_d;
      grst_n_q <= !(state_d == ST_IDLE || state_d == ST_RESET_PLAYERS);
      ie_q     <= (state_d == ST_FIGHT);
      done_q   <= (state_d == ST_MATCH_OVER);
    end
  end

  assign bus.game_rst_n   = grst_n_q;
  assign bus.input_enable = ie_q;
  assign bus.state        = state_q;
  assign bus.round_time   = rt_q;
  assign bus.round_num    = rn_q;
  assign bus.right_wins   = rw_q;
  assign bus.left_wins    = lw_q;
  assign bus.round_winner = rwin_q;
  assign bus.match_winner = mwin_q;
  assign bus.match_done   = done_q;

endmodule

// File: tb/tb_match_controller.sv
// Randomized bench for match_controller against a round-level model of the
// game rules (health schedule -> round end cycle -> result -> scoreboard).
module tb_match_controller;
  localparam int TD = 4;
  localparam int CT = 2;
  localparam int RT = 5;
  localparam int WM = 2;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  match_controller_if bus();

  match_controller #(
    .TICK_DIV(TD), .COUNTDOWN_TICKS(CT), .ROUND_TICKS(RT),
    .WINS_TO_MATCH(WM), .MAX_ROUNDS(MR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int m_lw, m_rw, m_rn, m_mwin;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int judge(input int hl, input int hr);
    if (hl == 0 && hr == 0) return 3;
    if (hl == 0) return 2;
    if (hr == 0) return 1;
    if (hl > hr) return 1;
    if (hr > hl) return 2;
    return 3;
  endfunction

  // Starts a match from IDLE or MATCH_OVER; scoreboard must read cleared
  task automatic start_match();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_lw = 0; m_rw = 0; m_rn = 0; m_mwin = 0;
    n_checks++;
    if ({bus.left_wins, bus.right_wins, bus.round_num, bus.round_winner, bus.match_winner, bus.match_done} !== 12'd0 || bus.state !== 3'd1)
      $display("FAIL start_clear state=%0d lw=%0d rw=%0d rn=%0d rwin=%0d mwin=%0d done=%b required state=1 all zero",
               bus.state, bus.left_wins, bus.right_wins, bus.round_num, bus.round_winner, bus.match_winner, bus.match_done);
    else n_pass++;
  endtask

  // Plays one round from the first RESET_PLAYERS cycle. Health is pre_* before
  // fight cycle ko and fin_* from then on. Random start pulses must be ignored.
  task automatic play_round(input int pre_l, input int pre_r, input int fin_l,
                            input int fin_r, input int ko, output bit over);
    int c_end, res, hl, hr, rt, exp_st, exp_g;
    for (int i = 0; i < 2 + CT * TD; i++) begin
      exp_st = (i < 2) ? 1 : 2;
      exp_g  = (i < 2) ? 0 : 1;
      n_checks++;
      if (bus.state !== 3'(exp_st) || bus.game_rst_n !== 1'(exp_g) || bus.input_enable !== 1'b0)
        $display("FAIL preamble cyc=%0d state=%0d grst=%b ie=%b required state=%0d grst=%0d ie=0",
                 i, bus.state, bus.game_rst_n, bus.input_enable, exp_st, exp_g);
      else n_pass++;
      bus.start = 1'($urandom_range(0, 1));
      bus.left_health  = 3'($urandom);
      bus.right_health = 3'($urandom);
      step();
    end
    // first fight cycle where a KO is visible or the clock has run out
    c_end = RT * TD;
    res   = 0;
    for (int c = RT * TD; c >= 0; c--) begin
      hl = (c >= ko) ? fin_l : pre_l;
      hr = (c >= ko) ? fin_r : pre_r;
      if (hl == 0 || hr == 0 || c == RT * TD) begin
        c_end = c;
        res   = judge(hl, hr);
      end
    end
    for (int c = 0; c <= c_end; c++) begin
      rt = RT - c / TD;
      if (rt < 0) rt = 0;
      n_checks++;
      if (bus.state !== 3'd3 || bus.input_enable !== 1'b1 || bus.game_rst_n !== 1'b1 || bus.round_time !== 8'(rt))
        $display("FAIL fight cyc=%0d state=%0d ie=%b grst=%b time=%0d required state=3 ie=1 grst=1 time=%0d",
                 c, bus.state, bus.input_enable, bus.game_rst_n, bus.round_time, rt);
      else n_pass++;
      bus.start = 1'($urandom_range(0, 1));
      bus.left_health  = 3'((c >= ko) ? fin_l : pre_l);
      bus.right_health = 3'((c >= ko) ? fin_r : pre_r);
      step();
    end
    m_rn++;
    if (res == 1) m_lw++;
    if (res == 2) m_rw++;
    for (int i = 0; i < TD; i++) begin
      n_checks++;
      if (bus.state !== 3'd4 || bus.round_winner !== 2'(res) || bus.left_wins !== 2'(m_lw) ||
          bus.right_wins !== 2'(m_rw) || bus.round_num !== 3'(m_rn) || bus.input_enable !== 1'b0)
        $display("FAIL round_end cyc=%0d state=%0d rwin=%0d lw=%0d rw=%0d rn=%0d ie=%b required state=4 rwin=%0d lw=%0d rw=%0d rn=%0d ie=0",
                 i, bus.state, bus.round_winner, bus.left_wins, bus.right_wins, bus.round_num, bus.input_enable,
                 res, m_lw, m_rw, m_rn);
      else n_pass++;
      bus.start = 1'($urandom_range(0, 1));
      bus.left_health  = 3'($urandom);
      bus.right_health = 3'($urandom);
      step();
    end
    bus.start = 1'b0;
    over = (m_lw == WM || m_rw == WM || m_rn == MR);
    if (over) begin
      m_mwin = (m_lw > m_rw) ? 1 : (m_rw > m_lw) ? 2 : 3;
      n_checks++;
      if (bus.state !== 3'd5 || bus.match_done !== 1'b1 || bus.match_winner !== 2'(m_mwin) ||
          bus.game_rst_n !== 1'b1 || bus.input_enable !== 1'b0)
        $display("FAIL match_over state=%0d done=%b mwin=%0d grst=%b ie=%b required state=5 done=1 mwin=%0d grst=1 ie=0",
                 bus.state, bus.match_done, bus.match_winner, bus.game_rst_n, bus.input_enable, m_mwin);
      else n_pass++;
    end else begin
      n_checks++;
      if (bus.state !== 3'd1 || bus.match_done !== 1'b0 || bus.game_rst_n !== 1'b0)
        $display("FAIL next_round state=%0d done=%b grst=%b required state=1 done=0 grst=0",
                 bus.state, bus.match_done, bus.game_rst_n);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.left_health = 3'd7;
    bus.right_health = 3'd7;
    step(); step();
    rst_n = 1'b1;
    n_checks++;
    if ({bus.state, bus.game_rst_n, bus.input_enable, bus.round_time, bus.round_num, bus.right_wins,
         bus.left_wins, bus.round_winner, bus.match_winner, bus.match_done} !== 27'd0)
      $display("FAIL reset state=%0d grst=%b ie=%b time=%0d rn=%0d rw=%0d lw=%0d rwin=%0d mwin=%0d done=%b required all zero",
               bus.state, bus.game_rst_n, bus.input_enable, bus.round_time, bus.round_num, bus.right_wins,
               bus.left_wins, bus.round_winner, bus.match_winner, bus.match_done);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bus.left_health  = 3'($urandom);
      bus.right_health = 3'($urandom);
      step();
      n_checks++;
      if (bus.state !== 3'd0 || bus.game_rst_n !== 1'b0)
        $display("FAIL idle_hold state=%0d grst=%b required state=0 grst=0", bus.state, bus.game_rst_n);
      else n_pass++;
    end
  endtask

  task automatic test_ko_left();
    bit over;
    start_match();
    play_round($urandom_range(1, 7), $urandom_range(1, 7), 0, $urandom_range(1, 7),
               $urandom_range(0, 15), over);
  endtask

  task automatic test_match_right();
    bit over;
    play_round(2, 6, 2, 6, 100, over);
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (bus.state !== 3'd5 || bus.match_done !== 1'b1 || bus.match_winner !== 2'd2)
        $display("FAIL match_hold state=%0d done=%b mwin=%0d required state=5 done=1 mwin=2",
                 bus.state, bus.match_done, bus.match_winner);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    start_match();
  endtask

  task automatic test_timeout_draw();
    bit over;
    play_round(4, 4, 4, 4, 100, over);
  endtask

  task automatic test_ko_priority();
    bit over;
    play_round(3, 5, 0, 0, RT * TD, over);
  endtask

  task automatic test_max_rounds();
    bit over;
    play_round(6, 6, 6, 6, 100, over);
  endtask

  task automatic test_random_matches();
    bit over;
    for (int m = 0; m < 4; m++) begin
      start_match();
      over = 1'b0;
      for (int r = 0; r < MR && !over; r++)
        play_round($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 24), over);
    end
  endtask

  task automatic test_reset_mid_fight();
    int extra;
    start_match();
    bus.left_health  = 3'd5;
    bus.right_health = 3'd5;
    extra = $urandom_range(1, 15);
    for (int i = 0; i < 2 + CT * TD + extra; i++) step();
    n_checks++;
    if (bus.state !== 3'd3 || bus.round_time === 8'd0)
      $display("FAIL mid_fight state=%0d time=%0d required state=3 time>0", bus.state, bus.round_time);
    else n_pass++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({bus.state, bus.game_rst_n, bus.input_enable, bus.round_time, bus.round_num, bus.right_wins,
         bus.left_wins, bus.round_winner, bus.match_winner, bus.match_done} !== 27'd0)
      $display("FAIL reset_mid_fight state=%0d grst=%b ie=%b time=%0d rn=%0d rwin=%0d required all zero",
               bus.state, bus.game_rst_n, bus.input_enable, bus.round_time, bus.round_num, bus.round_winner);
    else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.left_health = 3'd0;
    bus.right_health = 3'd0;
    test_reset();
    test_ko_left();
    test_match_right();
    test_restart();
    test_timeout_draw();
    test_ko_priority();
    test_max_rounds();
    test_random_matches();
    test_reset_mid_fight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
